instr_prefetch_queue: RTL and testbench

//   Instruction prefetch buffer directly upstream of I_FETCH's IF/ID register: issues in-order reads to the

---
 rtl/instr_prefetch_queue.sv | 143 ++++++++++++++
 tb/tb_instr_prefetch_queue.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: issues in-order imem reads, buffers {instr, pc} and hands them to IF.
// Define PREFETCH_BYPASS_EN to forward a returning word straight to deq_* when the queue is empty.
module instr_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                       CLK,
    input  logic                       RST,
    output logic                       imem_req,
    output logic [31:0]                imem_addr,
    input  logic                       imem_gnt,
    input  logic                       imem_rvalid,
    input  logic [31:0]                imem_rdata,
    output logic                       deq_valid,
    input  logic                       deq_ready,
    output logic [31:0]                deq_instr,
    output logic [31:0]                deq_pc,
    output logic [31:0]                deq_npc,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int OW = $clog2(MAX_OUT+1);
    localparam int RW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;

    state_t        r_state;
    logic [31:0]   r_fetch_pc;
    logic [OW-1:0] r_out;
    logic [OW-1:0] r_drop;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [RW-1:0] r_rpc_wr;
    logic [RW-1:0] r_rpc_rd;
    logic [31:0]   r_q_instr [DEPTH];
    logic [31:0]   r_q_pc    [DEPTH];
    logic [31:0]   r_rpc     [MAX_OUT];

    logic          w_grant;
    logic          w_enq;
    logic          w_deq;
    logic          w_byp;
    logic          w_nonempty;
    logic [OW-1:0] w_out_nxt;
    logic [31:0]   w_rsp_pc;

    function automatic logic [RW-1:0] rpc_inc(input logic [RW-1:0] p);
        return (p == RW'(MAX_OUT - 1)) ? '0 : p + RW'(1);
    endfunction

    // A slot is reserved per grant, so the queue cannot overflow when responses land.
    assign imem_req   = (r_state == RUN) && !redirect
                        && ((int'(r_count) + int'(r_out)) < DEPTH)
                        && (int'(r_out) < MAX_OUT);
    assign imem_addr  = r_fetch_pc;
    assign w_grant    = imem_req && imem_gnt;
    assign w_out_nxt  = r_out + OW'(w_grant) - OW'(imem_rvalid);
    assign w_rsp_pc   = r_rpc[r_rpc_rd];
    assign w_nonempty = (r_count != '0);

`ifdef PREFETCH_BYPASS_EN
    assign w_byp = (r_state == RUN) && !w_nonempty && imem_rvalid && deq_ready && !redirect;
`else
    assign w_byp = 1'b0;
`endif

    assign w_enq     = (r_state == RUN) && imem_rvalid && !redirect && !w_byp;
    assign deq_valid = (w_nonempty || w_byp) && !redirect;
    assign w_deq     = deq_valid && deq_ready && w_nonempty;
    assign deq_instr = w_byp ? imem_rdata : (w_nonempty ? r_q_instr[r_head] : 32'h0);
    assign deq_pc    = w_byp ? w_rsp_pc   : (w_nonempty ? r_q_pc[r_head]    : 32'h0);
    assign deq_npc   = deq_pc + 32'd4;
    assign count     = r_count;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= BOOT;
            r_fetch_pc <= RESET_PC;
            r_out      <= '0;
            r_drop     <= '0;
            r_count    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_rpc_wr   <= '0;
            r_rpc_rd   <= '0;
        end else begin
            r_out <= w_out_nxt;
            if (w_grant) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
                r_rpc_wr   <= rpc_inc(r_rpc_wr);
            end
            // The response-pc FIFO pops on every response, including ones that get dropped.
            if (imem_rvalid)
                r_rpc_rd <= rpc_inc(r_rpc_rd);
            case (r_state)
                BOOT: r_state <= RUN;
                RUN: begin
                    if (redirect) begin
                        r_fetch_pc <= redirect_pc;
                        r_count    <= '0;
                        r_head     <= '0;
                        r_tail     <= '0;
                        if (w_out_nxt != '0) begin
                            r_drop  <= w_out_nxt;
                            r_state <= DRAIN;
                        end
                    end else begin
                        if (w_enq)
                            r_tail <= r_tail + AW'(1);
                        if (w_deq)
                            r_head <= r_head + AW'(1);
                        r_count <= r_count + CW'(w_enq) - CW'(w_deq);
                    end
                end
                DRAIN: begin
                    if (redirect)
                        r_fetch_pc <= redirect_pc;
                    if (imem_rvalid) begin
                        r_drop <= r_drop - OW'(1);
                        if (r_drop == OW'(1))
                            r_state <= RUN;
                    end
                end
                default: r_state <= BOOT;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (w_enq) begin
            r_q_instr[r_tail] <= imem_rdata;
            r_q_pc[r_tail]    <= w_rsp_pc;
        end
        if (w_grant)
            r_rpc[r_rpc_wr] <= r_fetch_pc;
    end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue with a fixed-latency in-order imem model.
module tb_instr_prefetch_queue;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        deq_valid;
    logic        deq_ready = 1'b0;
    logic [31:0] deq_instr;
    logic [31:0] deq_pc;
    logic [31:0] deq_npc;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [2:0]  count;

    instr_prefetch_queue #(.DEPTH(4), .MAX_OUT(2), .RESET_PC(32'h0)) dut (
        .CLK(CLK), .RST(RST),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_instr(deq_instr),
        .deq_pc(deq_pc), .deq_npc(deq_npc),
        .redirect(redirect), .redirect_pc(redirect_pc), .count(count)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic [31:0] addr; int due; } rsp_t;
    rsp_t pend[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   lat = 1;
    int   cyc = 0;
    int   n_grant = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h8C02_0004 + a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else
            n_pass++;
    endtask

    // One clock: sample grant/response before the edge, update the memory model, present the next response.
    task automatic cycle();
        logic        g;
        logic        rv;
        logic [31:0] ga;
        rsp_t        r;
        #1;
        g  = imem_req && imem_gnt;
        ga = imem_addr;
        rv = imem_rvalid;
        @(posedge CLK);
        cyc++;
        if (rv && pend.size() > 0)
            void'(pend.pop_front());
        if (g) begin
            r.addr = ga;
            r.due  = cyc - 1 + lat;
            pend.push_back(r);
            n_grant++;
        end
        @(negedge CLK);
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
    endtask

    task automatic do_reset();
        RST = 1'b0;
        imem_gnt = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata = 32'h0;
        deq_ready = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        pend.delete();
        repeat (2) @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic wait_valid(input int lim, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            #1;
            if (deq_valid) begin
                ok = 1'b1;
                break;
            end
            cycle();
        end
    endtask

    initial begin
        logic ok;
        int   n_drop;

        // Reset values
        #2;
        RST = 1'b0;
        #1;
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", deq_valid, 0);
        chk("rst_instr", deq_instr, 32'h0);
        chk("rst_pc", deq_pc, 32'h0);
        chk("rst_count", count, 0);

        // 1: streaming with 1-cycle memory
        lat = 1;
        do_reset();
        deq_ready = 1'b1;
        wait_valid(10, ok);
        chk("t1_first_valid", ok, 1);
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("t1_valid", deq_valid, 1);
            chk("t1_pc", deq_pc, 32'(4 * i));
            chk("t1_npc", deq_npc, 32'(4 * i + 4));
            chk("t1_instr", deq_instr, mem_word(32'(4 * i)));
            cycle();
        end

        // 2: consumer stalled, queue fills to DEPTH
        do_reset();
        n_grant = 0;
        repeat (12) cycle();
        #1;
        chk("t2_grants", n_grant, 4);
        chk("t2_count", count, 4);
        chk("t2_req", imem_req, 0);
        deq_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_valid", deq_valid, 1);
            chk("t2_pc", deq_pc, 32'(4 * i));
            cycle();
        end

        // 3: redirect with two reads in flight
        lat = 3;
        do_reset();
        deq_ready = 1'b1;
        for (int i = 0; i < 10 && pend.size() < 2; i++)
            cycle();
        chk("t3_inflight", pend.size(), 2);
        redirect = 1'b1;
        redirect_pc = 32'h40;
        #1;
        chk("t3_req_redirect", imem_req, 0);
        cycle();
        redirect = 1'b0;
        n_drop = 0;
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (imem_req) begin
                ok = 1'b1;
                break;
            end
            if (imem_rvalid)
                n_drop++;
            chk("t3_drain_valid", deq_valid, 0);
            cycle();
        end
        chk("t3_req_seen", ok, 1);
        chk("t3_dropped", n_drop, 2);
        chk("t3_addr", imem_addr, 32'h40);
        wait_valid(12, ok);
        chk("t3_valid", ok, 1);
        chk("t3_pc", deq_pc, 32'h40);
        chk("t3_instr", deq_instr, mem_word(32'h40));

        // 4: redirect coinciding with deq_ready and rvalid at count=3
        lat = 1;
        do_reset();
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (count == 3 && imem_rvalid) begin
                ok = 1'b1;
                break;
            end
            cycle();
        end
        chk("t4_setup", ok, 1);
        deq_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h200;
        #1;
        chk("t4_valid_redirect", deq_valid, 0);
        cycle();
        redirect = 1'b0;
        #1;
        chk("t4_count", count, 0);
        chk("t4_valid_after", deq_valid, 0);
        chk("t4_req", imem_req, 1);
        chk("t4_addr", imem_addr, 32'h200);
        wait_valid(8, ok);
        chk("t4_refill", ok, 1);
        chk("t4_pc", deq_pc, 32'h200);

        // 5: asynchronous reset mid-stream
        do_reset();
        deq_ready = 1'b1;
        repeat (6) cycle();
        @(posedge CLK);
        #2;
        RST = 1'b0;
        #1;
        chk("t5_req", imem_req, 0);
        chk("t5_addr", imem_addr, 32'h0);
        chk("t5_valid", deq_valid, 0);
        chk("t5_instr", deq_instr, 32'h0);
        chk("t5_pc", deq_pc, 32'h0);
        chk("t5_count", count, 0);
        pend.delete();
        imem_rvalid = 1'b0;
        imem_rdata = 32'h0;
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("t5_boot_req", imem_req, 0);
        cycle();
        #1;
        chk("t5_run_req", imem_req, 1);
        chk("t5_run_addr", imem_addr, 32'h0);

        // 6: single word returning into an empty queue
        do_reset();
        imem_gnt = 1'b0;
        deq_ready = 1'b1;
        cycle();
        #1;
        chk("t6_req", imem_req, 1);
        imem_gnt = 1'b1;
        cycle();
        imem_gnt = 1'b0;
        #1;
        chk("t6_rvalid", imem_rvalid, 1);
        chk("t6_count0", count, 0);
`ifdef PREFETCH_BYPASS_EN
        chk("t6_byp_valid", deq_valid, 1);
        chk("t6_byp_pc", deq_pc, 32'h0);
        chk("t6_byp_instr", deq_instr, 32'h8C02_0004);
        cycle();
        #1;
        chk("t6_byp_count", count, 0);
        chk("t6_byp_after", deq_valid, 0);
`else
        chk("t6_valid_early", deq_valid, 0);
        cycle();
        #1;
        chk("t6_valid", deq_valid, 1);
        chk("t6_count1", count, 1);
        chk("t6_pc", deq_pc, 32'h0);
        chk("t6_instr", deq_instr, 32'h8C02_0004);
        cycle();
        #1;
        chk("t6_count_end", count, 0);
        chk("t6_after", deq_valid, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
